mips_multicycle_ctrl: RTL and testbench

- Moore FSM controller for the multi-cycle MIPS datapath. It sits on the driving side of the ALU interface.
- It produces the 4-bit ALU control code and all datapath selects and enables, and consumes the ALU zero flag.
- It decodes opcode/funct from the external instruction register. Supported set: add, sub, and, or, slt, nor, lw, sw, beq, addi, j.

---
 rtl/mips_multicycle_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Moore FSM controller for the multi-cycle MIPS datapath.
// Decodes opcode/funct from the instruction register and sequences the
// datapath selects/enables and the ALU control code through each instruction.
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic [3:0] aluCtrlSignal,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       pcEn,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t     state_q;
    state_t     state_d;
    logic       funct_ok;
    logic [3:0] funct_alu;

    // Internal (unmasked) enables; reset masking is applied at the ports.
    logic       pc_write;
    logic       branch_take;
    logic       mem_write_raw;
    logic       ir_write_raw;
    logic       reg_write_raw;

    // Map R-type funct to an ALU code and flag whether it is supported.
    always_comb begin
        funct_ok  = 1'b1;
        funct_alu = ALU_ADD;
        case (funct)
            6'h20:   funct_alu = ALU_ADD;
            6'h22:   funct_alu = ALU_SUB;
            6'h24:   funct_alu = ALU_AND;
            6'h25:   funct_alu = ALU_OR;
            6'h2A:   funct_alu = ALU_SLT;
            6'h27:   funct_alu = ALU_NOR;
            default: funct_ok  = 1'b0;
        endcase
    end

    // State register with synchronous reset back to FETCH.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // Next-state and Moore output decode from the registered state.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a variable unassigned (no latches).
        state_d       = FETCH;
        aluCtrlSignal = ALU_ADD;
        aluSrcA       = 1'b0;
        aluSrcB       = 2'b00;
        pcSrc         = 2'b00;
        pc_write      = 1'b0;
        branch_take   = 1'b0;
        iorD          = 1'b0;
        memRead       = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        regDst        = 1'b0;
        memToReg      = 1'b0;
        reg_write_raw = 1'b0;
        instrDone     = 1'b0;
        illegalOp     = 1'b0;

        case (state_q)
            FETCH: begin
                memRead      = 1'b1;
                ir_write_raw = 1'b1;
                pc_write     = 1'b1;
                aluSrcB      = 2'b01;
                state_d      = DECODE;
            end
            DECODE: begin
                // Precompute the branch target while the opcode is decoded.
                aluSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE: begin
                        if (funct_ok) state_d = EXECUTE;
                        else          illegalOp = 1'b1;
                    end
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default:      illegalOp = 1'b1;
                endcase
            end
            MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                memRead = 1'b1;
                iorD    = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                reg_write_raw = 1'b1;
                memToReg      = 1'b1;
                instrDone     = 1'b1;
            end
            MEMWR: begin
                mem_write_raw = 1'b1;
                iorD          = 1'b1;
                instrDone     = 1'b1;
            end
            EXECUTE: begin
                aluSrcA       = 1'b1;
                aluCtrlSignal = funct_alu;
                state_d       = ALUWB;
            end
            ALUWB: begin
                reg_write_raw = 1'b1;
                regDst        = 1'b1;
                instrDone     = 1'b1;
            end
            BRANCH: begin
                aluSrcA       = 1'b1;
                aluCtrlSignal = ALU_SUB;
                pcSrc         = 2'b01;
                branch_take   = zero;
                instrDone     = 1'b1;
            end
            ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                instrDone     = 1'b1;
            end
            JUMP: begin
                pc_write  = 1'b1;
                pcSrc     = 2'b10;
                instrDone = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // Architectural write enables are suppressed for as long as reset is held.
    assign pcEn     = (pc_write | branch_take) & ~reset;
    assign memWrite = mem_write_raw & ~reset;
    assign irWrite  = ir_write_raw & ~reset;
    assign regWrite = reg_write_raw & ~reset;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: each instruction is expanded
// into its expected per-cycle output table and compared every cycle.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic [3:0] aluCtrlSignal;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] pcSrc;
    logic       pcEn;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       memToReg;
    logic       regWrite;
    logic       instrDone;
    logic       illegalOp;
    logic [3:0] state;

    int n_checks = 0;
    int n_errors = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .aluCtrlSignal(aluCtrlSignal), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB),
        .pcSrc(pcSrc), .pcEn(pcEn), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst),
        .memToReg(memToReg), .regWrite(regWrite), .instrDone(instrDone),
        .illegalOp(illegalOp), .state(state)
    );

    always #5 clk = ~clk;

    // One expected cycle of an instruction.
    typedef struct {
        logic [3:0] st;
        logic [3:0] alu;
        logic       src_a;
        logic [1:0] src_b;
        logic [1:0] pc_src;
        logic       pc_write;
        logic       is_branch;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       done;
        logic       illegal;
    } rec_t;

    // Observed snapshot of one cycle, kept for literal checks.
    typedef struct {
        logic [3:0] st;
        logic [3:0] alu;
        logic       pc_en;
        logic [1:0] pc_src;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       done;
        logic       illegal;
    } obs_t;

    rec_t exp_q[$];
    obs_t seen[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic legal(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00:                             return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
            6'h23, 6'h2B, 6'h04, 6'h08, 6'h02: return 1'b1;
            default:                           return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            6'h27:   return 4'b1100;
            default: return 4'b0010;
        endcase
    endfunction

    function automatic rec_t mk(input logic [3:0] st);
        rec_t r;
        r = '{default: '0};
        r.st  = st;
        r.alu = 4'b0010;
        return r;
    endfunction

    // Expand one instruction into its full expected cycle table, FETCH first.
    task automatic build(input logic [5:0] op, input logic [5:0] fn);
        rec_t r;
        exp_q.delete();
        r = mk(4'd0); r.mem_read = 1; r.ir_write = 1; r.pc_write = 1; r.src_b = 2'b01;
        exp_q.push_back(r);
        r = mk(4'd1); r.src_b = 2'b11; r.illegal = !legal(op, fn);
        exp_q.push_back(r);
        if (!legal(op, fn)) return;
        case (op)
            6'h23, 6'h2B: begin
                r = mk(4'd2); r.src_a = 1; r.src_b = 2'b10; exp_q.push_back(r);
                if (op == 6'h23) begin
                    r = mk(4'd3); r.mem_read = 1; r.iord = 1; exp_q.push_back(r);
                    r = mk(4'd4); r.reg_write = 1; r.mem_to_reg = 1; r.done = 1; exp_q.push_back(r);
                end else begin
                    r = mk(4'd5); r.mem_write = 1; r.iord = 1; r.done = 1; exp_q.push_back(r);
                end
            end
            6'h00: begin
                r = mk(4'd6); r.src_a = 1; r.alu = alu_of(fn); exp_q.push_back(r);
                r = mk(4'd7); r.reg_write = 1; r.reg_dst = 1; r.done = 1; exp_q.push_back(r);
            end
            6'h04: begin
                r = mk(4'd8); r.src_a = 1; r.alu = 4'b0110; r.pc_src = 2'b01;
                r.is_branch = 1; r.done = 1; exp_q.push_back(r);
            end
            6'h08: begin
                r = mk(4'd9); r.src_a = 1; r.src_b = 2'b10; exp_q.push_back(r);
                r = mk(4'd10); r.reg_write = 1; r.done = 1; exp_q.push_back(r);
            end
            6'h02: begin
                r = mk(4'd11); r.pc_write = 1; r.pc_src = 2'b10; r.done = 1; exp_q.push_back(r);
            end
            default: ;
        endcase
    endtask

    // One clock: drive inputs, compare all outputs mid-cycle, then advance the model.
    // zmode: 0/1 hold zero at that value, 2 randomise it.
    task automatic do_cycle(input logic rst, input int zmode);
        rec_t e;
        obs_t o;
        logic we;
        reset = rst;
        zero  = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
        e = exp_q[0];
        we = ~rst;
        @(negedge clk);
        check("cyc state",     32'(state),         32'(e.st));
        check("cyc aluCtrl",   32'(aluCtrlSignal), 32'(e.alu));
        check("cyc aluSrcA",   32'(aluSrcA),       32'(e.src_a));
        check("cyc aluSrcB",   32'(aluSrcB),       32'(e.src_b));
        check("cyc pcSrc",     32'(pcSrc),         32'(e.pc_src));
        check("cyc pcEn",      32'(pcEn),          32'((e.pc_write | (e.is_branch & zero)) & we));
        check("cyc iorD",      32'(iorD),          32'(e.iord));
        check("cyc memRead",   32'(memRead),       32'(e.mem_read));
        check("cyc memWrite",  32'(memWrite),      32'(e.mem_write & we));
        check("cyc irWrite",   32'(irWrite),       32'(e.ir_write & we));
        check("cyc regDst",    32'(regDst),        32'(e.reg_dst));
        check("cyc memToReg",  32'(memToReg),      32'(e.mem_to_reg));
        check("cyc regWrite",  32'(regWrite),      32'(e.reg_write & we));
        check("cyc instrDone", 32'(instrDone),     32'(e.done));
        check("cyc illegalOp", 32'(illegalOp),     32'(e.illegal));
        o.st = state; o.alu = aluCtrlSignal; o.pc_en = pcEn; o.pc_src = pcSrc;
        o.mem_write = memWrite; o.reg_write = regWrite; o.reg_dst = regDst;
        o.mem_to_reg = memToReg; o.done = instrDone; o.illegal = illegalOp;
        seen.push_back(o);
        @(posedge clk);
        #1;
        if (rst) build(opcode, funct);
        else     void'(exp_q.pop_front());
    endtask

    // Run one instruction from FETCH; optionally assert reset at cycle rst_at for rst_len cycles.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int zmode,
                             input int rst_at, input int rst_len);
        opcode = op;
        funct  = fn;
        seen.delete();
        build(op, fn);
        for (int i = 0; i < 8 && exp_q.size() > 0; i++) begin
            if (i == rst_at) begin
                for (int k = 0; k < rst_len; k++) do_cycle(1'b1, zmode);
                break;
            end
            do_cycle(1'b0, zmode);
        end
    endtask

    function automatic logic [31:0] seen_states();
        logic [31:0] v = '0;
        foreach (seen[i]) v = (v << 4) | 32'(seen[i].st);
        return v;
    endfunction

    initial begin
        logic [5:0] op_list [6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h08, 6'h02};
        logic [5:0] fn_list [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, 6'h27};
        int any_flag;

        // Power-up reset: first edge must land in FETCH.
        reset = 1'b1; opcode = 6'h23; funct = 6'h00; zero = 1'b0;
        @(posedge clk);
        #1;
        check("reset state after first edge", 32'(state), 32'd0);
        build(opcode, funct);
        do_cycle(1'b1, 0);

        // lw: 0,1,2,3,4 and the next instruction begins on the 6th cycle.
        run_instr(6'h23, 6'h00, 0, -1, 0);
        check("lw state sequence", seen_states(), 32'h01234);
        check("lw MEMWB regWrite,memToReg,regDst,done",
              32'({seen[4].reg_write, seen[4].mem_to_reg, seen[4].reg_dst, seen[4].done}), 32'b1101);
        check("state after lw", 32'(state), 32'd0);

        // Reset held 2 cycles starting in MEMRD abandons the load.
        run_instr(6'h23, 6'h00, 0, 3, 2);
        check("reset from MEMRD sequence", seen_states(), 32'h01230);
        check("reset from MEMRD no write", 32'({seen[3].reg_write, seen[4].reg_write}), 32'b00);
        check("state after mid reset", 32'(state), 32'd0);

        // R-type sub / slt / nor.
        run_instr(6'h00, 6'h22, 0, -1, 0);
        check("sub EXECUTE alu", 32'(seen[2].alu), 32'b0110);
        check("sub sequence", seen_states(), 32'h0167);
        run_instr(6'h00, 6'h2A, 0, -1, 0);
        check("slt EXECUTE alu", 32'(seen[2].alu), 32'b0111);
        run_instr(6'h00, 6'h27, 0, -1, 0);
        check("nor EXECUTE alu", 32'(seen[2].alu), 32'b1100);
        check("ALUWB regWrite,regDst", 32'({seen[3].reg_write, seen[3].reg_dst}), 32'b11);

        // beq taken and not taken.
        run_instr(6'h04, 6'h00, 1, -1, 0);
        check("beq taken sequence", seen_states(), 32'h018);
        check("beq taken pcEn,pcSrc,alu", 32'({seen[2].pc_en, seen[2].pc_src, seen[2].alu}), 32'b1_01_0110);
        run_instr(6'h04, 6'h00, 0, -1, 0);
        check("beq not taken sequence", seen_states(), 32'h018);
        check("beq not taken pcEn", 32'(seen[2].pc_en), 32'd0);

        // sw then j back to back.
        run_instr(6'h2B, 6'h00, 0, -1, 0);
        check("sw sequence", seen_states(), 32'h0125);
        check("sw memWrite only in MEMWR",
              32'({seen[0].mem_write, seen[1].mem_write, seen[2].mem_write, seen[3].mem_write}), 32'b0001);
        run_instr(6'h02, 6'h00, 0, -1, 0);
        check("j sequence", seen_states(), 32'h01B);
        check("JUMP pcEn,pcSrc", 32'({seen[2].pc_en, seen[2].pc_src}), 32'b1_10);

        // Illegal opcode and illegal R-type funct.
        run_instr(6'h3F, 6'h00, 0, -1, 0);
        check("illegal op sequence", seen_states(), 32'h01);
        check("illegal op flag in DECODE", 32'(seen[1].illegal), 32'd1);
        check("back in FETCH after illegal op", 32'(state), 32'd0);
        run_instr(6'h00, 6'h00, 0, -1, 0);
        check("illegal funct sequence", seen_states(), 32'h01);
        any_flag = 0;
        foreach (seen[i]) any_flag |= int'(seen[i].reg_write | seen[i].mem_write | seen[i].done);
        check("illegal funct no side effects", 32'(any_flag), 32'd0);
        check("illegal funct flag in DECODE", 32'(seen[1].illegal), 32'd1);

        // Randomised instruction stream with occasional mid-instruction resets.
        for (int n = 0; n < 400; n++) begin
            int sel;
            logic [5:0] op;
            logic [5:0] fn;
            int rst_at;
            sel = $urandom_range(0, 7);
            fn  = fn_list[$urandom_range(0, 5)];
            if (sel < 6)       op = op_list[sel];
            else if (sel == 6) op = 6'($urandom);
            else begin
                op = 6'h00;
                fn = 6'($urandom);
            end
            rst_at = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 4) : -1;
            run_instr(op, fn, 2, rst_at, $urandom_range(1, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
